sram_pixel_fetcher: RTL and testbench
=====================================

Name: sram_pixel_fetcher

Overview:
- Upstream client of the SRAM controller.
- Streams frame-buffer words out of SRAM by issuing sequential read requests to the controller's request interface, and buffers the returned words in a small FIFO.
- The VGA/pixel pipeline drains the FIFO one word per request.
- Keeps the FIFO topped up so the display never starves, and flushes and rewinds at every frame start.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- FIFO_DEPTH, 16, prefetch FIFO entries; power of two, at least 4.
- RD_LATENCY, 2, cycles from request acceptance to valid mem_data.
- FB_BASE, 0, first word address of the frame buffer.
- FB_WORDS, 307200, words per frame; last address is FB_BASE+FB_WORDS-1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: flush the FIFO and rewind the address to FB_BASE.
- pix_rd  in  1  consumer pops the head word this cycle.
- pix_data  out  DATA_W  FIFO head, first-word-fall-through.
- pix_valid  out  1  FIFO non-empty.
- underflow  out  1  sticky: pix_rd seen while empty; cleared by frame_start or Reset.
- mem_ready  out  1  request strobe to the SRAM controller.
- mem_write_en  out  1  tied 0; this block only reads.
- mem_addr  out  ADDR_W  request address.
- mem_done  in  1  controller idle; a request is accepted when mem_ready and mem_done are both 1 at a rising edge.
- mem_data  in  DATA_W  read data, valid RD_LATENCY cycles after acceptance.

Behaviour:
- Reset values:
  - mem_ready=0, mem_write_en=0, mem_addr=FB_BASE.
  - pix_valid=0, pix_data=0, underflow=0.
  - FIFO empty, in-flight tracker clear, state IDLE.
- States:
  - IDLE: waits for the first frame_start; no requests are issued.
  - RUN: prefetching.
  - Transition IDLE->RUN on frame_start. Once in RUN, the block stays in RUN.
- Issue rule in RUN:
  - mem_ready=1 when (fifo_count + inflight) < FIFO_DEPTH and frame_start=0.
  - Credit check is combinational on the current count; it never overcommits the FIFO.
- On acceptance:
  - mem_addr advances next cycle.
  - If mem_addr == FB_BASE+FB_WORDS-1, it wraps to FB_BASE.
  - Back-to-back acceptance is legal whenever mem_done allows; the controller's busy cycles are absorbed by simply waiting.
- In-flight tracking:
  - Shift register of RD_LATENCY valid bits; a bit is inserted on acceptance.
  - When a bit emerges, mem_data is written to the FIFO that cycle.
  - inflight is the popcount of the shift register.
- FIFO:
  - Simultaneous write and pop: count unchanged, both take effect.
  - Pop while empty: ignored and sets underflow.
  - Write while full: cannot occur by the credit rule; it is an assertion target.
- frame_start (any state, including mid-flight):
  - Next cycle: FIFO empty, in-flight tracker cleared, so returning stale data is discarded.
  - mem_addr=FB_BASE, underflow=0.
  - No request is issued in the frame_start cycle itself.
  - A request accepted in the same cycle as frame_start is impossible, since mem_ready is forced 0.
- Simultaneous frame_start and pix_rd: flush wins; pix_rd is ignored and underflow is not set.
- Asynchronous Reset mid-operation: all state returns to reset values immediately. The SRAM controller is reset by the same Reset, so no orphaned requests remain.
- Widths:
  - Address arithmetic is ADDR_W unsigned, with the wrap compare done before the increment.
  - fifo_count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package sram_pkg:
  - SRAM_ADDR_W=20, SRAM_DATA_W=16.
  - typedef sram_addr_t, sram_word_t.
  - FB_BASE/FB_WORDS defaults (the controller uses the same widths).
- One sub-module: pixel_fifo.
  - Synchronous FWFT FIFO with async reset.
  - Parameters DEPTH and W.
  - Ports wr, wdata, rd, rdata, count, empty, full, flush.
- Credit logic, address counter, in-flight tracker and FSM live in sram_pixel_fetcher.

Test Plan:
- Reset then frame_start with mem_done=1, and a memory model returning data=addr after 2 cycles -> requests for addresses 0..15 on consecutive accepts; FIFO fills to 16; mem_ready drops; pix_valid=1; pix_data=0x0000.
- Pop one word per cycle from the full FIFO -> pix_data sequence 0,1,2,...; exactly one new request per pop; count stays between 14 and 16; no underflow.
- mem_done toggling 1,0 (controller busy every other cycle) -> requests are issued only on done cycles, and the address sequence has no gaps or duplicates.
- Force mem_addr near the end (FB_WORDS=8, FB_BASE=0x100), stream continuously -> addresses 0x100..0x107 then 0x100; pix_data follows the same order.
- frame_start while 2 reads are in flight with the FIFO holding 5 words -> next cycle pix_valid=0; the two stale returns are dropped; the first subsequent word is from FB_BASE.
- pix_rd with the FIFO empty -> underflow=1, held until the next frame_start; async Reset asserted mid-cycle -> all outputs reach reset values without waiting for a Clk edge.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM widths, frame-buffer defaults and fetcher state type,
// common to the SRAM controller and its clients.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W  = 20;
  localparam int unsigned SRAM_DATA_W  = 16;
  localparam int unsigned FB_BASE_DEF  = 0;
  localparam int unsigned FB_WORDS_DEF = 307200;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_word_t;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_RUN
  } fetch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// First-word-fall-through FIFO with async reset and synchronous flush;
// rdata reads as zero while empty.
module pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr,
  input  logic [W-1:0]           wdata,
  input  logic                   rd,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sram_pixel_fetcher.sv
// Prefetches sequential frame-buffer words from the SRAM controller into a
// small FIFO for the pixel pipeline; flushes and rewinds on frame_start.
module sram_pixel_fetcher
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W     = SRAM_ADDR_W,
  parameter int unsigned DATA_W     = SRAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FB_BASE    = FB_BASE_DEF,
  parameter int unsigned FB_WORDS   = FB_WORDS_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              mem_ready,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = $clog2(RD_LATENCY + 1);
  localparam int unsigned SW = CW + IW;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_BASE + FB_WORDS - 1);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [RD_LATENCY-1:0] infl;
  logic [IW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         credit_used;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  accept;
  logic                  emerge;
  logic                  pop;

  assign mem_write_en = 1'b0;
  assign accept       = mem_ready && mem_done;
  assign emerge       = infl[RD_LATENCY-1];
  assign pop          = pix_rd && !frame_start;
  assign pix_valid    = !fifo_empty;
  assign credit_used  = SW'(fifo_count) + SW'(inflight);

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) inflight = inflight + IW'(infl[i]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= FETCH_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) state_nxt = FETCH_RUN;
  end

  // Credits count words already buffered plus reads still in flight.
  always_comb begin
    mem_ready = (state == FETCH_RUN) && !frame_start && (credit_used < SW'(FIFO_DEPTH));
  end

  // Clearing the tracker on frame_start drops data from reads issued before it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_addr  <= BASE;
      infl      <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      mem_addr  <= BASE;
      infl      <= '0;
      underflow <= 1'b0;
    end else begin
      infl <= (infl << 1) | RD_LATENCY'(accept);
      if (accept) mem_addr <= (mem_addr == LAST) ? BASE : mem_addr + 1'b1;
      if (pix_rd && fifo_empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && !frame_start) assert (!(emerge && fifo_full && !pop));
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .flush (frame_start),
    .wr    (emerge),
    .wdata (mem_data),
    .rd    (pop),
    .rdata (pix_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_sram_pixel_fetcher.sv
// Directed and randomized bench for sram_pixel_fetcher against a queue-based
// model of the pixel stream, the address walk and the credit rule.
module tb_sram_pixel_fetcher;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LAT    = 2;
  localparam int unsigned BASE   = 32'h100;
  localparam int unsigned WORDS  = 24;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } pend_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              frame_start = 1'b0;
  logic              pix_rd = 1'b0;
  logic              mem_done = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underflow;
  logic              mem_ready;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;

  int                errors = 0;
  int                checks = 0;
  int                edge_n = 0;
  logic [DATA_W-1:0] q[$];
  pend_t             pend[$];
  logic [DATA_W-1:0] mq[LAT];
  int unsigned       exp_addr = BASE;
  logic              exp_uf = 1'b0;
  logic              running = 1'b0;

  sram_pixel_fetcher #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .RD_LATENCY (LAT),
    .FB_BASE    (BASE),
    .FB_WORDS   (WORDS)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_start  (frame_start),
    .pix_rd       (pix_rd),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .underflow    (underflow),
    .mem_ready    (mem_ready),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_done     (mem_done),
    .mem_data     (mem_data)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend.delete();
    exp_addr = BASE;
    exp_uf   = 1'b0;
    running  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_ready"}, mem_ready, 0);
    chk({tag, "_mem_we"}, mem_write_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_underflow"}, underflow, 0);
  endtask

  // One clock: drive inputs after negedge, compare before posedge, update model.
  task automatic tick(input logic fs, input logic rd, input logic done);
    logic  exp_ready;
    logic  dut_acc;
    pend_t p;
    frame_start = fs;
    pix_rd      = rd;
    mem_done    = done;
    #1;
    exp_ready = running && !fs && (int'(q.size()) + int'(pend.size()) < int'(DEPTH));
    chk("mem_ready", mem_ready, exp_ready);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_write_en", mem_write_en, 0);
    chk("pix_valid", pix_valid, q.size() != 0);
    if (q.size() != 0) chk("pix_data", pix_data, q[0]);
    chk("underflow", underflow, exp_uf);
    dut_acc = mem_ready && mem_done;
    @(posedge Clk);
    edge_n++;
    if (fs) begin
      q.delete();
      pend.delete();
      exp_addr = BASE;
      exp_uf   = 1'b0;
      running  = 1'b1;
    end else begin
      if (rd) begin
        if (q.size() != 0) void'(q.pop_front());
        else exp_uf = 1'b1;
      end
      while (pend.size() != 0 && pend[0].due == edge_n) begin
        p = pend.pop_front();
        q.push_back(p.data);
      end
      if (exp_ready && done) begin
        p.data = DATA_W'(exp_addr);
        p.due  = edge_n + int'(LAT);
        pend.push_back(p);
        exp_addr = (exp_addr == BASE + WORDS - 1) ? BASE : exp_addr + 1;
      end
    end
    for (int i = int'(LAT) - 1; i > 0; i--) mq[i] = mq[i-1];
    mq[0] = dut_acc ? DATA_W'(mem_addr) : DATA_W'($urandom);
    @(negedge Clk);
    mem_data = mq[LAT-1];
  endtask

  initial begin
    for (int i = 0; i < int'(LAT); i++) mq[i] = '0;
    #1 Reset = 1'b1;
    #1 check_reset_values("reset");
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    // IDLE: nothing issued before the first frame_start
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);

    // Fill: 16 sequential requests, then credit exhausted
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1);
    chk("fill_valid", pix_valid, 1);
    chk("fill_head", pix_data, BASE);
    chk("fill_ready", mem_ready, 0);

    // Continuous drain, crossing the frame-buffer wrap
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'b1);
    chk("drain_no_underflow", underflow, 0);

    // Controller busy every other cycle
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, 1'(i % 2));

    // Randomized traffic with occasional frame restarts
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));

    // Flush with 5 buffered words and 2 reads in flight
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("flush_valid", pix_valid, 0);
    chk("flush_addr", mem_addr, BASE);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    chk("flush_first_valid", pix_valid, 1);
    chk("flush_first_word", pix_data, BASE);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1);

    // Underflow is sticky until frame_start; frame_start+pix_rd does not set it
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("underflow_set", underflow, 1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    chk("underflow_held", underflow, 1);
    tick(1'b1, 1'b1, 1'b0);
    chk("underflow_cleared", underflow, 0);
    tick(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle while streaming
    for (int i = 0; i < 12; i++) tick(1'b0, 1'(i % 3 == 0), 1'b1);
    #3 Reset = 1'b1;
    #1 check_reset_values("async_reset");
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < int'(LAT); i++) mq[i] = '0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
